spi_slave: RTL and testbench

//  SPI mode-3 responder: the far end of the team's spi_master.

---
 rtl/spi_slave.sv | 149 ++++++++++++++
 tb/tb_spi_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-3 responder: exchanges one DW-bit word per ss-low frame, with ss/sck/din oversampled on clk.
// Latency: done pulses SYNC+1 clk after the DW-th sck rising edge reaches the pin.
// Backpressure: none; a new word overwrites rdata (ovr flags an unacknowledged overwrite when SPI_SLAVE_OVR_EN is defined).
//
// Ports: clk/rstb (async active-low reset); mlb selects MSB-first (1) or LSB-first (0);
//   tdat is the reply word latched at ss falling; ss/sck/din come from the master;
//   dout returns data (1 when idle); busy is high during a frame; done strobes when rdata updates.
// Optional macro SPI_SLAVE_OVR_EN adds rack (in) / ovr (out) overwrite tracking.
module spi_slave #(
    parameter int DW   = 8,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          mlb,
    input  logic [DW-1:0] tdat,
    input  logic          ss,
    input  logic          sck,
    input  logic          din,
`ifdef SPI_SLAVE_OVR_EN
    input  logic          rack,
    output logic          ovr,
`endif
    output logic          dout,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata
);

    localparam int NBW = $clog2(DW + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

    state_t          state, state_nx;
    logic [SYNC-1:0] ss_q, sck_q, din_q;
    logic            ss_d, sck_d;
    logic            ss_s, sck_s, din_s;
    logic            ss_fall, ss_rise, sck_rise, sck_fall;
    logic [DW-1:0]   treg, rreg, rnext, tnext;
    logic [NBW-1:0]  nbit;
    logic            last;

    // Synchronizers idle at the bus idle levels so reset never fakes an edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ss_q  <= '1;
            sck_q <= '1;
            din_q <= '1;
            ss_d  <= 1'b1;
            sck_d <= 1'b1;
        end else begin
            ss_q  <= {ss_q[SYNC-2:0], ss};
            sck_q <= {sck_q[SYNC-2:0], sck};
            din_q <= {din_q[SYNC-2:0], din};
            ss_d  <= ss_s;
            sck_d <= sck_s;
        end
    end

    assign ss_s     = ss_q[SYNC-1];
    assign sck_s    = sck_q[SYNC-1];
    assign din_s    = din_q[SYNC-1];
    assign ss_fall  = ss_d & ~ss_s;
    assign ss_rise  = ~ss_d & ss_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    // din is synchronized with the same depth as sck, so din_s is settled on sck_rise.
    assign rnext = mlb ? {rreg[DW-2:0], din_s} : {din_s, rreg[DW-1:1]};
    assign tnext = mlb ? {treg[DW-2:0], 1'b1}  : {1'b1, treg[DW-1:1]};
    assign last  = sck_rise && (nbit == NBW'(DW - 1));
    assign busy  = (state == S_SHIFT);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ss_fall) state_nx = S_SHIFT;
            // A final sck_rise coinciding with ss_rise still completes the word.
            S_SHIFT: if (last)         state_nx = ss_rise ? S_IDLE : S_WAIT;
                     else if (ss_rise) state_nx = S_IDLE;
            S_WAIT:  if (ss_rise) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dout  <= 1'b1;
            done  <= 1'b0;
            rdata <= '1;
            treg  <= '1;
            rreg  <= '1;
            nbit  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    dout <= 1'b1;
                    if (ss_fall) begin
                        treg <= tdat;
                        dout <= mlb ? tdat[DW-1] : tdat[0];
                        nbit <= '0;
                        rreg <= '1;
                    end
                end
                S_SHIFT: begin
                    if (sck_rise) begin
                        rreg <= rnext;
                        nbit <= nbit + 1'b1;
                        if (last) begin
                            rdata <= rnext;
                            done  <= 1'b1;
                            dout  <= 1'b1;
                        end
                    end else if (sck_fall && nbit != '0) begin
                        // The first falling edge finds the first bit already on dout.
                        treg <= tnext;
                        dout <= mlb ? tnext[DW-1] : tnext[0];
                    end
                    if (ss_rise && !last) dout <= 1'b1;
                end
                default: dout <= 1'b1;
            endcase
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    // pend marks an unacknowledged rdata; a rack coinciding with done acks the old word.
    logic pend;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pend <= 1'b0;
            ovr  <= 1'b0;
        end else if (done) begin
            pend <= 1'b1;
            ovr  <= rack ? 1'b0 : (ovr | pend);
        end else if (rack) begin
            pend <= 1'b0;
            ovr  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic       clk;
    logic       rstb;
    logic       mlb;
    logic [7:0] tdat;
    logic       ss;
    logic       sck;
    logic       din;
    logic       dout;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
`ifdef SPI_SLAVE_OVR_EN
    logic       rack;
    logic       ovr;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int idle_cnt = 0;
    bit mon_en = 0;
    logic [7:0] exp_word    = 8'hFF;
    logic [7:0] model_rdata = 8'hFF;

    spi_slave #(.DW(8), .SYNC(2)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .mlb   (mlb),
        .tdat  (tdat),
        .ss    (ss),
        .sck   (sck),
        .din   (din),
`ifdef SPI_SLAVE_OVR_EN
        .rack  (rack),
        .ovr   (ovr),
`endif
        .dout  (dout),
        .busy  (busy),
        .done  (done),
        .rdata (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-3 master: sck idles high, data changes on falling edges, sampled on rising edges.
    // half is the sck half-period in clk cycles (4*(cdiv+1)).
    task automatic frame(input logic m, input logic [7:0] td, input logic [7:0] word,
                         input int half, input int nbits, output logic [7:0] rx);
        @(negedge clk);
        mlb = m;
        tdat = td;
        exp_word = word;
        rx = 8'h00;
        wclk(2);
        ss = 1'b0;
        wclk(half);
        tdat = ~td;  // must not affect the word already latched
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b0;
            din = m ? word[7-i] : word[i];
            wclk(half);
            sck = 1'b1;
            rx = m ? {rx[6:0], dout} : {dout, rx[7:1]};
            if (i == 0) chk("busy_in_frame", 32'(busy), 32'd1);
            wclk(half);
        end
        ss  = 1'b1;
        din = 1'b1;
        wclk(12);
    endtask

    // Compare process: rdata only changes on a done pulse, and then to the word the master sent;
    // with ss idle long enough, dout must be 1 and busy 0.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (ss) idle_cnt++;
                else    idle_cnt = 0;
                if (done === 1'b1) begin
                    done_cnt++;
                    chk("done_word", 32'(rdata), 32'(exp_word));
                    model_rdata = exp_word;
                end else begin
                    chk("rdata_hold", 32'(rdata), 32'(model_rdata));
                end
                if (idle_cnt > 6) begin
                    chk("idle_dout", 32'(dout), 32'd1);
                    chk("idle_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [7:0] rx;
        int d0;
        rstb = 1'b0;
        mlb  = 1'b1;
        tdat = 8'h00;
        ss   = 1'b1;
        sck  = 1'b1;
        din  = 1'b1;
`ifdef SPI_SLAVE_OVR_EN
        rack = 1'b0;
`endif
        wclk(3);
        chk("rst_dout",  32'(dout),  32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_rdata", 32'(rdata), 32'hFF);
        rstb = 1'b1;
        mon_en = 1;
        wclk(4);

        // MSB first, fastest sck
        d0 = done_cnt;
        frame(1'b1, 8'hA5, 8'h3C, 4, 8, rx);
        chk("f1_master_rx", 32'(rx), 32'hA5);
        chk("f1_rdata", 32'(rdata), 32'h3C);
        chk("f1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Abort after 4 rising edges
        d0 = done_cnt;
        frame(1'b1, 8'h99, 8'hF0, 4, 4, rx);
        chk("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'h3C);
        chk("abort_dout", 32'(dout), 32'd1);

        d0 = done_cnt;
        frame(1'b1, 8'h5A, 8'hC3, 4, 8, rx);
        chk("f2_master_rx", 32'(rx), 32'h5A);
        chk("f2_rdata", 32'(rdata), 32'hC3);
        chk("f2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // LSB first, cdiv=3
        d0 = done_cnt;
        frame(1'b0, 8'h81, 8'h55, 16, 8, rx);
        chk("f3_master_rx", 32'(rx), 32'h81);
        chk("f3_rdata", 32'(rdata), 32'h55);
        chk("f3_done_cnt", 32'(done_cnt - d0), 32'd1);

        // LSB first, asymmetric patterns
        d0 = done_cnt;
        frame(1'b0, 8'h01, 8'hB2, 8, 8, rx);
        chk("f4_master_rx", 32'(rx), 32'h01);
        chk("f4_rdata", 32'(rdata), 32'hB2);
        chk("f4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset mid-frame
        @(negedge clk);
        mlb  = 1'b1;
        tdat = 8'h77;
        wclk(2);
        ss = 1'b0;
        wclk(4);
        sck = 1'b0;
        din = 1'b0;
        wclk(4);
        sck = 1'b1;
        wclk(4);
        sck = 1'b0;
        wclk(2);
        chk("mid_busy", 32'(busy), 32'd1);
        rstb = 1'b0;
        ss   = 1'b1;
        sck  = 1'b1;
        din  = 1'b1;
        model_rdata = 8'hFF;
        wclk(1);
        chk("mrst_dout",  32'(dout),  32'd1);
        chk("mrst_done",  32'(done),  32'd0);
        chk("mrst_rdata", 32'(rdata), 32'hFF);
        chk("mrst_busy",  32'(busy),  32'd0);
        wclk(2);
        rstb = 1'b1;
        wclk(6);

        d0 = done_cnt;
        frame(1'b1, 8'h0F, 8'h12, 4, 8, rx);
        chk("f5_master_rx", 32'(rx), 32'h0F);
        chk("f5_rdata", 32'(rdata), 32'h12);
        chk("f5_done_cnt", 32'(done_cnt - d0), 32'd1);

`ifdef SPI_SLAVE_OVR_EN
        @(negedge clk);
        rack = 1'b1;
        wclk(1);
        rack = 1'b0;
        wclk(1);
        chk("ovr_clear0", 32'(ovr), 32'd0);
        frame(1'b1, 8'h00, 8'h11, 4, 8, rx);
        chk("ovr_after_one", 32'(ovr), 32'd0);
        frame(1'b1, 8'h00, 8'h22, 4, 8, rx);
        chk("ovr_after_two", 32'(ovr), 32'd1);
        chk("ovr_rdata", 32'(rdata), 32'h22);
        @(negedge clk);
        rack = 1'b1;
        wclk(1);
        rack = 1'b0;
        wclk(1);
        chk("ovr_after_rack", 32'(ovr), 32'd0);
`endif

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
